ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte per request (for example 0xED set-LEDs, 0xFF reset, 0xF4 enable) to the attached keyboard, using the PS/2 inhibit/request-to-send sequence, odd parity, stop bit and device ACK. It is the transmit counterpart of the `keyboard` receiver, shares the same PS/2 pins in the Hack platform top through open-drain enables, and asserts `rx_inhibit` so the receiver ignores the bus while a command is in flight.

## Interface
- `FREQ`, 25: clock frequency in MHz.
- `INHIBIT_US`, 100: length of the clock-low inhibit phase, in µs.
- `TIMEOUT_US`, 15000: limit on the whole transaction, measured from the end of inhibit to the ACK, in µs.

- `clk` input 1: system clock (pixel clock domain).
- `rst_n` input 1: asynchronous, active-low reset.
- `tx_valid` input 1: request to send `tx_data`.
- `tx_data` input 8: command byte.
- `tx_ready` output 1: block is idle and can accept a byte.
- `done` output 1: one-cycle pulse when the device ACK is received.
- `error` output 1: one-cycle pulse on a timeout or a missing ACK.
- `busy` output 1: a transaction is in progress.
- `rx_inhibit` output 1: equal to `busy`; the receiver discards bus activity while it is high.
- `ps2_clk_in` input 1: raw PS/2 clock pin level.
- `ps2_data_in` input 1: raw PS/2 data pin level.
- `ps2_clk_oe` output 1: 1 pulls the PS/2 clock low; 0 releases it.
- `ps2_data_oe` output 1: 1 pulls the PS/2 data line low; 0 releases it.

## Operation
- Both PS/2 inputs pass through a 2-flop synchronizer followed by a history flop. A falling edge is `fall = prev & ~sync` on the synchronized clock.
- States:
  - IDLE: both lines released. `tx_ready` = 1. On `tx_valid` = 1, latch `tx_data`, compute `parity = ~^tx_data` (odd parity), then go to INHIBIT.
  - INHIBIT: `ps2_clk_oe` = 1 for `FREQ*INHIBIT_US` cycles. In the last cycle `ps2_data_oe` goes to 1 (start bit), then go to REQ.
  - REQ: clock released, data held low. The timeout counter starts. On the first `fall`, drive data bit 0 and go to SHIFT.
  - SHIFT: on each `fall`, the 4-bit edge count advances.
    - Edges 2–8 drive bits 1–7, LSB first.
    - Edge 9 drives parity.
    - Edge 10 releases data (stop bit).
    - Edge 11 samples the synchronized data line and goes to WAIT_IDLE. Low means ACK; high means error.
    - Driving a bit means setting `ps2_data_oe = ~bit`.
  - WAIT_IDLE: wait until both synchronized lines are high, then pulse `done` (on ACK) or `error` (on no ACK) and return to IDLE.
- Timeout:
  - The counter runs from REQ entry and is `$clog2(FREQ*TIMEOUT_US+1)` bits wide.
  - Reaching `FREQ*TIMEOUT_US` in any state other than IDLE or INHIBIT releases both lines, pulses `error` and returns to IDLE.
- `tx_valid` while `tx_ready` = 0 is ignored. Nothing is queued.

## Timing
- Reset values: state IDLE, `ps2_clk_oe` = 0, `ps2_data_oe` = 0, `done` = 0, `error` = 0, `busy` = 0, `tx_ready` = 1. The data latch and counters reset to 0.
- Assertion of `rst_n` mid-transaction releases both lines immediately, because the reset is asynchronous. The device then times out on its own.
- Acceptance: `tx_valid` is sampled at a rising edge with `tx_ready` = 1. In the next cycle `busy` = 1, `tx_ready` = 0 and `ps2_clk_oe` = 1.
- Inhibit lasts exactly `FREQ*INHIBIT_US` cycles (2500 at the defaults). `ps2_data_oe` rises one cycle before `ps2_clk_oe` falls.
- Edge-to-drive latency: `ps2_data_oe` updates 3 `clk` cycles after the pin falls (2 synchronizer cycles plus the registered output). This is well inside the PS/2 clock-low half-period.
- `done` and `error` are mutually exclusive, each lasts exactly one cycle, and either one coincides with `busy` falling.
- `tx_ready` returns to 1 in the cycle after `done` or `error`.
- Back-to-back: `tx_valid` held high is accepted in the first cycle with `tx_ready` = 1.

## Structure
- `ps2_pkg` holds:
  - the state enum (IDLE, INHIBIT, REQ, SHIFT, WAIT_IDLE);
  - `PS2_FRAME_EDGES` = 11, `PS2_ACK_EDGE` = 11, `PS2_PARITY_EDGE` = 9, `PS2_STOP_EDGE` = 10.
- The keyboard receiver reuses the same package.
- Sub-module `ps2_sync` contains the 2-flop synchronizer, the history flop and the falling-edge output. It is shared with `keyboard`.
- The top level combines the open-drain enables into `inout` pins.

## Test plan
- Send 0xED with a device model that ACKs. Bits on edges 1–8 are 1,0,1,1,0,1,1,1, parity on edge 9 is 1, the stop bit is released, and `done` pulses once. Clock low is 2500 cycles.
- Send 0xF4 → parity 0. Send 0x02 → parity 0. Send 0x00 → parity 1. All three complete with `done`.
- Device holds data high on the 11th edge → `error` pulses, `done` stays 0, and the block returns to IDLE with both lines released.
- Device never clocks after the request → after 375000 cycles `error` pulses and `ps2_data_oe` = 0.
- Hold `tx_valid` with 0xFF and then 0xF4 during a transaction → only the first byte is sent, and the second is accepted after `done`.
- Assert `rst_n` low at edge 5 → both enables are 0 immediately and `tx_ready` = 1 after release. A following send of 0xED completes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: controller state encoding, frame edge numbers
// and the parity helper used by the host transmitter and the keyboard receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_WAIT_IDLE
  } ps2_state_t;

  localparam int PS2_FRAME_EDGES = 11;
  localparam int PS2_ACK_EDGE    = 11;
  localparam int PS2_PARITY_EDGE = 9;
  localparam int PS2_STOP_EDGE   = 10;

  // Odd parity: the parity bit makes the total count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Synchronizes the raw PS/2 clock and data pins into clk and flags falling
// edges of the synchronized PS/2 clock.
module ps2_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic [1:0] clk_meta;
  logic [1:0] data_meta;
  logic       clk_prev;

  // NOTE: flops reset to 1 (bus idle level) so leaving reset cannot fake a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta  <= 2'b11;
      data_meta <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the old value, forming a real shift chain.
      clk_meta  <= {clk_meta[0], ps2_clk_in};
      data_meta <= {data_meta[0], ps2_data_in};
      clk_prev  <= clk_meta[1];
    end
  end

  assign clk_sync  = clk_meta[1];
  assign data_sync = data_meta[1];
  assign clk_fall  = clk_prev & ~clk_meta[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 8 data
// bits LSB first, odd parity, stop, device ACK, with a whole-transaction timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int FREQ       = 25,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       done,
  output logic       error,
  output logic       busy,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INH_CYC = FREQ * INHIBIT_US;
  localparam int TO_CYC  = FREQ * TIMEOUT_US;
  localparam int INH_W   = $clog2(INH_CYC + 1);
  localparam int TO_W    = $clog2(TO_CYC + 1);

  localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INH_CYC - 2);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INH_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYC);

  ps2_state_t       state, state_n;
  logic [7:0]       data_q, data_n;
  logic             par_q, par_n;
  logic             ack_q, ack_n;
  logic [INH_W-1:0] inh_cnt, inh_n;
  logic [3:0]       edge_cnt, edge_n;
  logic [TO_W-1:0]  to_cnt, to_n;
  logic             clk_oe_n, data_oe_n, done_n, error_n;

  logic clk_sync, data_sync, clk_fall;

  ps2_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .clk_sync   (clk_sync),
    .data_sync  (data_sync),
    .clk_fall   (clk_fall)
  );

  // tx_ready lags busy by one cycle so the done/error cycle never accepts.
  assign busy       = (state != ST_IDLE);
  assign rx_inhibit = busy;
  assign tx_ready   = (state == ST_IDLE) & ~done & ~error;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      data_q      <= '0;
      par_q       <= 1'b0;
      ack_q       <= 1'b0;
      inh_cnt     <= '0;
      edge_cnt    <= '0;
      to_cnt      <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_n;
      data_q      <= data_n;
      par_q       <= par_n;
      ack_q       <= ack_n;
      inh_cnt     <= inh_n;
      edge_cnt    <= edge_n;
      to_cnt      <= to_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      done        <= done_n;
      error       <= error_n;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n   = state;
    data_n    = data_q;
    par_n     = par_q;
    ack_n     = ack_q;
    inh_n     = inh_cnt;
    edge_n    = edge_cnt;
    to_n      = to_cnt;
    clk_oe_n  = ps2_clk_oe;
    data_oe_n = ps2_data_oe;
    done_n    = 1'b0;
    error_n   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (tx_valid && tx_ready) begin
          data_n   = tx_data;
          par_n    = odd_parity(tx_data);
          inh_n    = '0;
          edge_n   = '0;
          clk_oe_n = 1'b1;
          state_n  = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        inh_n = inh_cnt + INH_W'(1);
        if (inh_cnt == INH_PRE) data_oe_n = 1'b1;
        if (inh_cnt == INH_LAST) begin
          clk_oe_n = 1'b0;
          // The first REQ cycle already counts toward the timeout.
          to_n     = TO_W'(1);
          state_n  = ST_REQ;
        end
      end

      ST_REQ, ST_SHIFT, ST_WAIT_IDLE: begin
        to_n = to_cnt + TO_W'(1);
        if (state == ST_REQ) begin
          if (clk_fall) begin
            data_oe_n = ~data_q[0];
            edge_n    = 4'd1;
            state_n   = ST_SHIFT;
          end
        end else if (state == ST_SHIFT) begin
          if (clk_fall) begin
            edge_n = edge_cnt + 4'd1;
            if (edge_n <= 4'd8) begin
              data_oe_n = ~data_q[edge_cnt[2:0]];
            end else if (edge_n == 4'(PS2_PARITY_EDGE)) begin
              data_oe_n = ~par_q;
            end else if (edge_n == 4'(PS2_STOP_EDGE)) begin
              data_oe_n = 1'b0;
            end else if (edge_n == 4'(PS2_ACK_EDGE)) begin
              data_oe_n = 1'b0;
              ack_n     = ~data_sync;
              state_n   = ST_WAIT_IDLE;
            end
          end
        end else if (clk_sync && data_sync) begin
          done_n  = ack_q;
          error_n = ~ack_q;
          state_n = ST_IDLE;
        end

        if (to_cnt == TO_LAST) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          done_n    = 1'b0;
          error_n   = 1'b1;
          state_n   = ST_IDLE;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: an open-drain PS/2 device model clocks out
// each frame, and byte/parity/ACK outcomes come from a hand-computed vector table.
module tb_ps2_host_tx;

  localparam int FREQ    = 2;
  localparam int INH_US  = 50;
  localparam int TO_US   = 500;
  localparam int INH_CYC = FREQ * INH_US;   // 100 cycles of clock inhibit
  localparam int TO_CYC  = FREQ * TO_US;    // 1000 cycle transaction limit
  localparam int H       = 10;              // device clock half period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, done, error, busy, rx_inhibit;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk, dev_data;
  logic       ps2_clk_in, ps2_data_in;

  // Wired-AND open-drain bus: either side can pull a line low.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.FREQ(FREQ), .INHIBIT_US(INH_US), .TIMEOUT_US(TO_US)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .done       (done),
    .error      (error),
    .busy       (busy),
    .rx_inhibit (rx_inhibit),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse and handshake monitor, sampled on the falling clk edge.
  int done_cnt = 0, error_cnt = 0, both_cnt = 0, pulse_bad = 0, ready_late = 0, inh_bad = 0;
  int since_pulse = 0, rise_gap = 0;
  logic pulse_q = 1'b0, busy_q = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt <= done_cnt + 1;
      if (error) error_cnt <= error_cnt + 1;
      if (done && error) both_cnt <= both_cnt + 1;
      if ((done || error) && (busy || tx_ready)) pulse_bad <= pulse_bad + 1;
      if (pulse_q && !tx_ready) ready_late <= ready_late + 1;
      if (rx_inhibit !== busy) inh_bad <= inh_bad + 1;
      since_pulse <= (done || error) ? 0 : since_pulse + 1;
      if (busy && !busy_q) rise_gap <= since_pulse + 1;
      pulse_q <= done | error;
      busy_q  <= busy;
    end else begin
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end
  end

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Counts cycles with the clock pulled low, and how many of them also pull data.
  task automatic measure_inhibit(output int clk_low, output int lead);
    clk_low = 0;
    lead    = 0;
    while (ps2_clk_oe && clk_low < 4 * INH_CYC) begin
      clk_low++;
      if (ps2_data_oe) lead++;
      @(negedge clk);
    end
  endtask

  // Device clocks 11 falling edges; the line is read at the end of each low half.
  task automatic device_frame(input logic ack, output logic [10:0] line_bits);
    line_bits = '0;
    repeat (H) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack) dev_data = 1'b0;
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      line_bits[k-1] = ps2_data_in;
      dev_clk = 1'b1;
      if (k == 11) dev_data = 1'b1;
      repeat (H) @(negedge clk);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!tx_ready && n < 2 * TO_CYC) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait_bound", 32'(n < 2 * TO_CYC), 1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic       parity;
  } vec_t;

  task automatic run_vec(input vec_t v);
    logic [10:0] bits;
    int clk_low, lead, d0, e0;
    d0 = done_cnt;
    e0 = error_cnt;
    start_tx(v.data);
    check("accept_busy_ready_clkoe", {busy, tx_ready, ps2_clk_oe}, 3'b101);
    measure_inhibit(clk_low, lead);
    check("inhibit_len", clk_low, INH_CYC);
    check("start_bit_lead", lead, 1);
    device_frame(v.ack, bits);
    check("data_bits", bits[7:0], v.data);
    check("parity_bit", bits[8], v.parity);
    check("stop_bit", bits[9], 1);
    wait_ready();
    check("done_pulses", done_cnt - d0, 32'(v.ack));
    check("error_pulses", error_cnt - e0, 32'(!v.ack));
    check("released", {tx_ready, ps2_clk_oe, ps2_data_oe}, 3'b100);
  endtask

  vec_t vecs[5];

  initial begin
    logic [10:0] bits;
    int clk_low, lead, n, d0, e0;

    vecs[0] = '{data: 8'hED, ack: 1'b1, parity: 1'b1};
    vecs[1] = '{data: 8'hF4, ack: 1'b1, parity: 1'b0};
    vecs[2] = '{data: 8'h02, ack: 1'b1, parity: 1'b0};
    vecs[3] = '{data: 8'h00, ack: 1'b1, parity: 1'b1};
    vecs[4] = '{data: 8'h3C, ack: 1'b0, parity: 1'b1};

    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", {tx_ready, busy, rx_inhibit, ps2_clk_oe, ps2_data_oe, done, error},
          7'b1000000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Device never clocks: timeout counted from clock release.
    d0 = done_cnt;
    e0 = error_cnt;
    start_tx(8'hF4);
    measure_inhibit(clk_low, lead);
    check("req_data_low", ps2_data_oe, 1);
    n = 0;
    while (!error && n < 2 * TO_CYC) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, TO_CYC);
    check("timeout_released", {ps2_clk_oe, ps2_data_oe, busy}, 3'b000);
    wait_ready();
    check("timeout_error_pulse", error_cnt - e0, 1);
    check("timeout_no_done", done_cnt - d0, 0);

    // tx_valid held through a transaction: second byte waits for the first to finish.
    d0 = done_cnt;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    @(negedge clk);
    tx_data  = 8'hF4;
    measure_inhibit(clk_low, lead);
    device_frame(1'b1, bits);
    check("hold_first_byte", bits[7:0], 8'hFF);
    check("hold_second_busy", busy, 1);
    tx_valid = 1'b0;
    check("hold_accept_gap", rise_gap, 2);
    n = 0;
    while (ps2_clk_oe && n < 4 * INH_CYC) begin
      @(negedge clk);
      n++;
    end
    device_frame(1'b1, bits);
    check("hold_second_byte", bits[7:0], 8'hF4);
    wait_ready();
    check("hold_done_pulses", done_cnt - d0, 2);

    // Reset while the clock is low after the fifth edge.
    start_tx(8'hED);
    measure_inhibit(clk_low, lead);
    repeat (H) @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      if (k < 5) begin
        dev_clk = 1'b1;
        repeat (H) @(negedge clk);
      end
    end
    check("pre_reset_bit4_driven", ps2_data_oe, 1);
    rst_n = 1'b0;
    #1;
    check("reset_releases", {ps2_clk_oe, ps2_data_oe, busy}, 3'b000);
    dev_clk = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", tx_ready, 1);
    run_vec(vecs[0]);

    check("done_error_overlap", both_cnt, 0);
    check("pulse_while_busy_or_ready", pulse_bad, 0);
    check("ready_after_pulse", ready_late, 0);
    check("rx_inhibit_tracks_busy", inh_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
